// File: rtl/cla_operand_sequencer_pkg.sv
// Shared types and constants for the CLA operand sequencer and checker.
package cla_seq_pkg;

  localparam int unsigned OPW  = 4;
  localparam int unsigned RESW = 5;
  localparam logic [7:0]  ERR_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    STEP
  } state_e;

  function automatic logic [RESW-1:0] golden_sum(input logic [OPW-1:0] a,
                                                 input logic [OPW-1:0] b,
                                                 input logic           cin);
    return {1'b0, a} + {1'b0, b} + {{(RESW-1){1'b0}}, cin};
  endfunction

endpackage

// File: rtl/cla_operand_sequencer_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_q[1];
        press_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cla_operand_sequencer.sv
// Drives operands into the CLA adder, checks its result against a golden sum,
// and optionally sweeps all 512 {cin,b,a} vectors.
module cla_operand_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  sw_a,
  input  logic [OPW-1:0]  sw_b,
  input  logic            sw_cin,
  input  logic            btn_load,
  input  logic            btn_auto,
  input  logic [RESW-1:0] sum_in,
  output logic [OPW-1:0]  op_a,
  output logic [OPW-1:0]  op_b,
  output logic            op_cin,
  output logic            res_valid,
  output logic            mismatch,
  output logic [7:0]      err_count,
  output logic            auto_active
);

  localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned VW  = 2 * OPW + 1;

  logic            load_press, auto_press;
  logic [VW-1:0]   sw_s1_q, sw_s2_q;
  state_e          state_q, state_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic [VW-1:0]   ops_q, ops_d;
  logic            auto_q, auto_d;
  logic            res_valid_q, res_valid_d;
  logic            mismatch_q, mismatch_d;
  logic [7:0]      err_q, err_d;
  logic [RESW-1:0] golden;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_load (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_load), .press_o(load_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_auto (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_auto), .press_o(auto_press)
  );

  assign golden = golden_sum(ops_q[OPW-1:0], ops_q[2*OPW-1:OPW], ops_q[VW-1]);

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    ops_d       = ops_q;
    auto_d      = auto_q;
    res_valid_d = 1'b0;
    mismatch_d  = mismatch_q;
    err_d       = err_q;
    // An abort outranks every state action, including a pending check.
    if (auto_q && auto_press) begin
      auto_d  = 1'b0;
      state_d = IDLE;
      scnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_press) begin
            ops_d   = sw_s2_q;
            state_d = SETTLE;
            scnt_d  = '0;
          end else if (auto_press) begin
            ops_d   = '0;
            auto_d  = 1'b1;
            state_d = SETTLE;
            scnt_d  = '0;
          end
        end
        SETTLE: begin
          if (scnt_q == SCW'(SETTLE_CYCLES - 1)) begin
            scnt_d  = '0;
            state_d = CHECK;
          end else begin
            scnt_d = scnt_q + SCW'(1);
          end
        end
        CHECK: begin
          res_valid_d = 1'b1;
          mismatch_d  = (sum_in != golden);
          if ((sum_in != golden) && (err_q != ERR_MAX)) err_d = err_q + 8'd1;
          state_d = auto_q ? STEP : IDLE;
        end
        STEP: begin
          ops_d = ops_q + VW'(1);
          if (ops_q == '1) begin
            auto_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = SETTLE;
            scnt_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      state_q     <= IDLE;
      scnt_q      <= '0;
      ops_q       <= '0;
      auto_q      <= 1'b0;
      res_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      sw_s1_q     <= {sw_cin, sw_b, sw_a};
      sw_s2_q     <= sw_s1_q;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      ops_q       <= ops_d;
      auto_q      <= auto_d;
      res_valid_q <= res_valid_d;
      mismatch_q  <= mismatch_d;
      err_q       <= err_d;
    end
  end

  assign op_a        = ops_q[OPW-1:0];
  assign op_b        = ops_q[2*OPW-1:OPW];
  assign op_cin      = ops_q[VW-1];
  assign res_valid   = res_valid_q;
  assign mismatch    = mismatch_q;
  assign err_count   = err_q;
  assign auto_active = auto_q;

endmodule
